// File: rtl/nds_frame_writer_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between nds_frame_writer and the interconnect.
interface nds_frame_writer_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );
endinterface

// File: rtl/nds_frame_writer.sv
// NDS LCD capture: synchronise the pixel bus, queue formatted pixels, write them out over AXI4-Lite.
// Optional ping-pong frame buffers via the NDS_DOUBLE_BUFFER_EN macro.
module nds_frame_writer #(
  parameter int          COLOR_W    = 6,
  parameter int          H_PIXELS   = 256,
  parameter int          V_LINES    = 192,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR0 = 32'h0000_0000,
  parameter logic [31:0] BASE_ADDR1 = 32'h0003_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [COLOR_W-1:0] red,
  input  logic [COLOR_W-1:0] green,
  input  logic [COLOR_W-1:0] blue,
  input  logic               dclk,
  input  logic               ls,
  input  logic               gsp,
  nds_frame_writer_if.master axi,
  output logic               frame_done,
  output logic               active_buf,
  output logic               overflow,
  output logic               resp_err
);
  localparam int X_W   = $clog2(H_PIXELS + 1);
  localparam int Y_W   = $clog2(V_LINES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [X_W-1:0] X_END  = X_W'(H_PIXELS);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_END  = Y_W'(V_LINES);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_LINES - 1);

  typedef enum logic [1:0] {C_IDLE, C_CAPTURE, C_DRAIN} cap_state_t;
  typedef enum logic [1:0] {M_IDLE, M_WRITE, M_RESP}    mst_state_t;

  cap_state_t cap_state;
  mst_state_t m_state;

  // MSB replication up to 8 bits; the top 8 bits of {c, c} are exactly that.
  function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
    return 8'({c, c} >> (2 * COLOR_W - 8));
  endfunction

  // ---------------- input synchronisers ----------------
  logic [2:0]           dclk_sync, ls_sync, gsp_sync;
  logic [3*COLOR_W-1:0] rgb_s1, rgb_s2;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      dclk_sync <= '0;
      ls_sync   <= '0;
      gsp_sync  <= '1;
      rgb_s1    <= '0;
      rgb_s2    <= '0;
    end else begin
      dclk_sync <= {dclk_sync[1:0], dclk};
      ls_sync   <= {ls_sync[1:0], ls};
      gsp_sync  <= {gsp_sync[1:0], gsp};
      rgb_s1    <= {red, green, blue};
      rgb_s2    <= rgb_s1;
    end
  end

  logic dclk_rise, ls_rise, gsp_fall;
  assign dclk_rise = dclk_sync[1] & ~dclk_sync[2];
  assign ls_rise   = ls_sync[1] & ~ls_sync[2];
  assign gsp_fall  = ~gsp_sync[1] & gsp_sync[2];

  // ---------------- pixel formatting ----------------
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic [31:0]    base_addr, pix_addr, pix_data;

  // active_buf is held at 0 unless double buffering is built in, so BASE_ADDR1 is then never selected.
  assign base_addr = active_buf ? BASE_ADDR1 : BASE_ADDR0;
  assign pix_addr  = base_addr + ((32'(y_cnt) * 32'(H_PIXELS) + 32'(x_cnt)) << 2);
  assign pix_data  = {8'h00,
                      expand(rgb_s2[3*COLOR_W-1 -: COLOR_W]),
                      expand(rgb_s2[2*COLOR_W-1 -: COLOR_W]),
                      expand(rgb_s2[COLOR_W-1:0])};

  // ---------------- pixel FIFO ----------------
  logic [63:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_empty, fifo_full, push_req, push, pop;
  logic [63:0]    fifo_head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign pop        = (m_state == M_IDLE) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    // NOTE: default first so no path leaves push_req unassigned (no latch).
    push_req = 1'b0;
    if (cap_state == C_CAPTURE && dclk_rise && !ls_rise && !gsp_fall &&
        x_cnt != X_END && y_cnt != Y_END)
      push_req = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: storage array is deliberately not reset; pointers alone define validity.
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {pix_addr, pix_data};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- capture FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_state  <= C_IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      frame_done <= 1'b0;
      active_buf <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (gsp_fall) begin
        // Frame start, or abandonment of the frame in progress; queued entries keep their addresses.
        x_cnt <= '0;
        y_cnt <= '0;
        if (enable) begin
          cap_state <= C_CAPTURE;
          overflow  <= 1'b0;
        end else begin
          cap_state <= C_IDLE;
        end
      end else begin
        case (cap_state)
          C_CAPTURE: begin
            if (ls_rise) begin
              if (x_cnt != '0) begin
                x_cnt <= '0;
                if (y_cnt != Y_END) y_cnt <= y_cnt + 1'b1;
              end
            end else if (push_req) begin
              x_cnt <= x_cnt + 1'b1;
              if (!push) overflow <= 1'b1;
              if (x_cnt == X_LAST && y_cnt == Y_LAST) cap_state <= C_DRAIN;
            end
          end
          C_DRAIN: begin
            if (fifo_empty && m_state == M_IDLE) begin
              cap_state  <= C_IDLE;
              frame_done <= 1'b1;
`ifdef NDS_DOUBLE_BUFFER_EN
              active_buf <= ~active_buf;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- AXI4-Lite write master ----------------
  logic aw_left, w_left;
  assign aw_left = axi.S_AXI_AWVALID & ~axi.S_AXI_AWREADY;
  assign w_left  = axi.S_AXI_WVALID  & ~axi.S_AXI_WREADY;
  assign axi.S_AXI_WSTRB = 4'b1111;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_state           <= M_IDLE;
      axi.S_AXI_AWADDR  <= '0;
      axi.S_AXI_AWVALID <= 1'b0;
      axi.S_AXI_WDATA   <= '0;
      axi.S_AXI_WVALID  <= 1'b0;
      axi.S_AXI_BREADY  <= 1'b0;
      resp_err          <= 1'b0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (pop) begin
            axi.S_AXI_AWADDR  <= fifo_head[63:32];
            axi.S_AXI_WDATA   <= fifo_head[31:0];
            axi.S_AXI_AWVALID <= 1'b1;
            axi.S_AXI_WVALID  <= 1'b1;
            m_state           <= M_WRITE;
          end
        end
        M_WRITE: begin
          if (axi.S_AXI_AWVALID && axi.S_AXI_AWREADY) axi.S_AXI_AWVALID <= 1'b0;
          if (axi.S_AXI_WVALID && axi.S_AXI_WREADY)   axi.S_AXI_WVALID  <= 1'b0;
          if (!aw_left && !w_left) begin
            axi.S_AXI_BREADY <= 1'b1;
            m_state          <= M_RESP;
          end
        end
        M_RESP: begin
          if (axi.S_AXI_BVALID) begin
            axi.S_AXI_BREADY <= 1'b0;
            m_state          <= M_IDLE;
            if (axi.S_AXI_BRESP != 2'b00) resp_err <= 1'b1;
          end
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end
endmodule

// File: doc/nds_frame_writer.md
# nds_frame_writer

Parametrised NDS LCD capture engine: synchronises the NDS pixel bus (dclk/ls/gsp, RGB) into the AXI clock domain, counts pixels into a fixed frame geometry, queues formatted pixels in a FIFO and writes them to frame memory through an AXI4-Lite write master with full AW/W/B handshaking. Sits between the NDS LCD pins and the BRAM/AXI interconnect, feeding the frame buffer read by the video output path.

## Interface
- COLOR_W, 6: bits per colour channel; legal 5..8.
- H_PIXELS, 256: active pixels per line.
- V_LINES, 192: active lines per frame.
- FIFO_DEPTH, 16: pixel FIFO entries; power of two, ≥4.
- BASE_ADDR0, 32'h0000_0000: frame buffer 0 base (byte address).
- BASE_ADDR1, 32'h0003_0000: frame buffer 1 base; used only with NDS_DOUBLE_BUFFER_EN.

- clk  in  1  AXI clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  capture enable, sampled at frame start.
- red, green, blue  in  COLOR_W each  NDS pixel data, asynchronous.
- dclk  in  1  NDS pixel clock, asynchronous; pixel valid on rising edge.
- ls  in  1  NDS line start, asynchronous, active high.
- gsp  in  1  NDS frame start, asynchronous, active low.
- S_AXI_AWADDR  out  32  write address.
- S_AXI_AWVALID / S_AXI_AWREADY  out / in  1  address handshake.
- S_AXI_WDATA  out  32  {8'h00, r8, g8, b8}.
- S_AXI_WSTRB  out  4  constant 4'b1111.
- S_AXI_WVALID / S_AXI_WREADY  out / in  1  data handshake.
- S_AXI_BRESP  in  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  in / out  1  response handshake.
- frame_done  out  1  one-cycle pulse when last pixel of a complete frame is acknowledged.
- active_buf  out  1  buffer currently being written.
- overflow  out  1  sticky: pixel dropped on FIFO full.
- resp_err  out  1  sticky: BRESP != OKAY seen.

## Operation
- dclk, ls, gsp, RGB pass through a 2-flop synchroniser; a third dclk/ls/gsp stage provides edge detection. Requires clk ≥ 4× dclk frequency.
- Colour expansion: c8 = {c, c[COLOR_W-1 -: 8-COLOR_W]} (MSB replication); COLOR_W=8 passes through.
- Capture FSM: IDLE → CAPTURE on synchronised gsp falling edge with enable=1 (x=0, y=0, overflow cleared). CAPTURE → DRAIN when pixel (H_PIXELS-1, V_LINES-1) is pushed. DRAIN → IDLE when FIFO empty and no write outstanding; frame_done pulses on that transition.
- In CAPTURE, each dclk rising edge with x<H_PIXELS and y<V_LINES pushes {addr, data}, addr = base + (y*H_PIXELS + x)*4 (32-bit arithmetic, wraps mod 2^32); x increments. Pixels beyond x=H_PIXELS-1 are discarded silently.
- ls rising edge: if x≠0, y increments; x←0. ls with x=0 does nothing.
- gsp falling edge in CAPTURE or DRAIN: current frame abandoned, counters restart, no frame_done, active_buf unchanged; already-queued entries still drain to their original addresses.
- FIFO full on push: pixel dropped, x still increments, overflow←1.
- Write master: one transaction outstanding. Pop FIFO → assert AWVALID and WVALID together; each deasserts independently after its handshake; BREADY asserted after both complete until BVALID; next pop only after B handshake. AWADDR/WDATA held stable while valid.
- BRESP ≠ 2'b00: resp_err←1; transaction not retried.

## Timing
- Reset values: AWVALID=0, WVALID=0, BREADY=0, AWADDR=0, frame_done=0, active_buf=0, overflow=0, resp_err=0, FSM=IDLE, FIFO empty.
- Pixel latency: dclk high sampled at clk edge N → FIFO push at N+2 → AWVALID/WVALID high at N+3 (master idle, FIFO empty).
- Max throughput with AWREADY=WREADY=BVALID=1: one pixel per 3 clk.
- Push and pop in the same cycle on a full FIFO: push accepted, no overflow.
- reset_n low mid-transaction: valids drop next edge; interconnect is reset together.
- overflow/resp_err clear only on reset; overflow also on accepted frame start.

## Configuration
- NDS_DOUBLE_BUFFER_EN defined: base = active_buf ? BASE_ADDR1 : BASE_ADDR0; active_buf toggles on each frame_done, so consumers read the other buffer.
- Undefined: base always BASE_ADDR0, active_buf constant 0.

## Test plan
- Geometry 4×2, ready always 1, one frame → 8 writes at 0x00..0x1C, frame_done once, data {8'h00,r8,g8,b8} with 6'h3F→8'hFF, 6'h20→8'h82.
- AWREADY delayed 3 clk, WREADY immediate → WVALID drops after W handshake, AWVALID held with stable AWADDR, BREADY only after both.
- FIFO_DEPTH=4, BVALID held low 40 clk during burst → overflow=1, surviving pixels at correct addresses, frame_done still pulses.
- gsp falling edge after 5 pixels of line 1 → no frame_done, next frame starts at base+0, queued entries complete.
- NDS_DOUBLE_BUFFER_EN, two full frames → frame 1 at BASE_ADDR0, frame 2 at BASE_ADDR1, active_buf 0→1→0.
- BRESP=2'b10 on third write → resp_err=1, capture continues, reset_n low clears it.
